counter_down6: RTL and testbench
================================

COUNTER_DOWN6 -- requirements
Module: counter_down6

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset is synchronous and active-low; sampled on rising clk edge.
REQ-003 enablen  input  1  active-low count enable (typically the lower digit's rco_L).
REQ-004 load  input  1  active-high synchronous parallel load strobe.
REQ-005 in  input  4  parallel load value, unsigned.
REQ-006 next_count_state  input  4  lower-digit next state, unsigned BCD, used only for terminal-count decode.
REQ-007 count  output  4  current state, unsigned, always in range 0..5.
REQ-008 rco_L  output  1  active-low ripple carry/borrow out, combinational.

Function
REQ-009 States S0..S5 map to count 0..5; count SHALL never take values 6..15.
REQ-010 Per rising edge, priority: reset > load > count > hold.
REQ-011 load=1: count SHALL take the load value at the next edge, regardless of enablen.
REQ-012 Load value: in when in<=5; in>5 handled per REQ-021/REQ-022.
REQ-013 load=0 and enablen=0: count SHALL decrement by 1 at the next edge; S0 wraps to S5.
REQ-014 load=0 and enablen=1: count SHALL hold.
REQ-015 rco_L SHALL be 0 iff count==0 and enablen==0 and next_count_state==9; otherwise 1.
REQ-016 rco_L SHALL be purely combinational from count, enablen and next_count_state, with no clock latency and no glitch-free guarantee.
REQ-017 X/Z on in while load=0 SHALL not affect count.

Reset
REQ-018 rst=0 at a rising edge SHALL set count to 0 (S0), overriding load and enablen.
REQ-019 With count=0 after reset, rco_L follows REQ-015; no separate reset value is forced.
REQ-020 Reset deasserted mid-count SHALL resume from S0 on the next qualifying edge.

Configuration
REQ-021 Macro COUNTER_DOWN6_LOAD_CLAMP_EN defined: load with in>5 SHALL load 5 (S5).
REQ-022 Macro COUNTER_DOWN6_LOAD_CLAMP_EN undefined: load with in>5 SHALL be ignored and count holds its value; load with in<=5 is unaffected.

Verification
REQ-023 rst=0 for one edge, then rst=1, enablen=0, load=0 -> count 0 then 5,4,3,2,1,0,5 on successive edges.
REQ-024 in=9, load=1 for one edge, next_count_state=0 -> count=5 with clamp macro, count unchanged without it; rco_L stays 1 throughout.
REQ-025 in=5, load=1 held for 3 edges with enablen=0 -> count stays 5 while load=1, then decrements 4,3,... after release; rco_L=1 with next_count_state=0.
REQ-026 in=7 loaded with clamp macro, next_count_state=9, enablen=0 -> count 5..1 with rco_L=1, at count=0 rco_L=0 combinationally, next edge count=5 and rco_L=1.
REQ-027 in=1 loaded, next_count_state=9, enablen=0 -> count 1, then 0 with rco_L=0, then wrap S0->S5; set enablen=1 at count=0 -> rco_L=1 and count holds.
REQ-028 rst=0 asserted with load=1 and in=3 on the same edge -> count=0.

Source files
------------

// File: rtl/counter_down6.sv
// Mod-6 down counter digit (5..0, wrapping to 5) with synchronous load and an active-low ripple carry.
// Build option COUNTER_DOWN6_LOAD_CLAMP_EN: out-of-range loads (in > 5) clamp to 5 instead of being ignored.
module counter_down6 (
  input  logic       clk,
  input  logic       rst,
  input  logic       enablen,
  input  logic       load,
  input  logic [3:0] in,
  input  logic [3:0] next_count_state,
  output logic [3:0] count,
  output logic       rco_L
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5
  } state_t;

  state_t state_reg;
  state_t state_next;
  state_t dec_state;
  state_t load_state;
  logic   load_in_range;

  // Wrap S0 back to S5; unreachable encodings fall back to S0 so count stays in 0..5.
  always_comb begin
    dec_state = S0;
    case (state_reg)
      S0:      dec_state = S5;
      S1:      dec_state = S0;
      S2:      dec_state = S1;
      S3:      dec_state = S2;
      S4:      dec_state = S3;
      S5:      dec_state = S4;
      default: dec_state = S0;
    endcase
  end

  assign load_in_range = (in <= 4'd5);

  always_comb begin
    load_state = state_reg;
    if (load_in_range) begin
      load_state = state_t'(in[2:0]);
    end else begin
`ifdef COUNTER_DOWN6_LOAD_CLAMP_EN
      load_state = S5;
`else
      load_state = state_reg;
`endif
    end
  end

  // in is only consulted while load is high, so X/Z on it cannot disturb counting or holding.
  always_comb begin
    state_next = state_reg;
    if (load) begin
      state_next = load_state;
    end else if (!enablen) begin
      state_next = dec_state;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= S0;
    end else begin
      state_reg <= state_next;
    end
  end

  assign count = {1'b0, state_reg};

  // Borrow ripples out only when this digit is at 0, enabled, and the lower digit is about to wrap from 9.
  assign rco_L = ~((state_reg == S0) && !enablen && (next_count_state == 4'd9));

endmodule

// File: tb/tb_counter_down6.sv
// Directed table-driven bench for counter_down6, plus hand-written sequences for the
// combinational rco_L corners; expectations follow COUNTER_DOWN6_LOAD_CLAMP_EN when defined.
module tb_counter_down6;

`ifdef COUNTER_DOWN6_LOAD_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       enablen;
  logic       load;
  logic [3:0] in;
  logic [3:0] next_count_state;
  logic [3:0] count;
  logic       rco_L;

  int errors;
  int checks;

  counter_down6 dut (
    .clk              (clk),
    .rst              (rst),
    .enablen          (enablen),
    .load             (load),
    .in               (in),
    .next_count_state (next_count_state),
    .count            (count),
    .rco_L            (rco_L)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       load;
    logic       enablen;
    logic [3:0] in;
    logic [3:0] ncs;
    logic [3:0] exp_count;
    logic       exp_rco;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic l, input logic e, input logic [3:0] i,
                              input logic [3:0] n, input logic [3:0] ec, input logic er);
    vec_t v;
    v.rst = r; v.load = l; v.enablen = e; v.in = i; v.ncs = n;
    v.exp_count = ec; v.exp_rco = er;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic l, input logic e, input logic [3:0] i,
                       input logic [3:0] n);
    rst = r; load = l; enablen = e; in = i; next_count_state = n;
  endtask

  task automatic step_check(input string name, input logic [3:0] ec, input logic er);
    @(posedge clk);
    #1;
    $display("%s: rst=%b load=%b enablen=%b in=%h ncs=%0d -> count=%0d rco_L=%b",
             name, rst, load, enablen, in, next_count_state, count, rco_L);
    check({name, " count"}, count, ec);
    check({name, " rco_L"}, {3'b0, rco_L}, {3'b0, er});
  endtask

  initial begin
    errors = 0;
    checks = 0;
    drive(1'b1, 1'b0, 1'b1, 4'd0, 4'd0);

    // reset, then free-running decrement with wrap
    add(0, 0, 0, 4'd0, 4'd0, 4'd0, 1);
    add(1, 0, 0, 4'd0, 4'd0, 4'd5, 1);
    add(1, 0, 0, 4'd0, 4'd0, 4'd4, 1);
    add(1, 0, 0, 4'd0, 4'd0, 4'd3, 1);
    add(1, 0, 0, 4'd0, 4'd0, 4'd2, 1);
    add(1, 0, 0, 4'd0, 4'd0, 4'd1, 1);
    add(1, 0, 0, 4'd0, 4'd0, 4'd0, 1);
    add(1, 0, 0, 4'd0, 4'd0, 4'd5, 1);
    add(1, 0, 0, 4'd0, 4'd0, 4'd4, 1);
    add(1, 0, 0, 4'd0, 4'd0, 4'd3, 1);
    // out-of-range load, then hold with X on in
    add(1, 1, 0, 4'd9, 4'd0, CLAMP ? 4'd5 : 4'd3, 1);
    add(1, 0, 1, 4'bxxxx, 4'd0, CLAMP ? 4'd5 : 4'd3, 1);
    // load held three edges beats enablen, then release
    add(1, 1, 0, 4'd5, 4'd0, 4'd5, 1);
    add(1, 1, 0, 4'd5, 4'd0, 4'd5, 1);
    add(1, 1, 0, 4'd5, 4'd0, 4'd5, 1);
    add(1, 0, 0, 4'd5, 4'd0, 4'd4, 1);
    add(1, 0, 0, 4'd5, 4'd0, 4'd3, 1);
    // reset overrides load
    add(0, 1, 1, 4'd3, 4'd0, 4'd0, 1);
    add(1, 1, 1, 4'd2, 4'd0, 4'd2, 1);
    add(1, 1, 0, 4'd0, 4'd9, 4'd0, 0);
    // load 1, count through terminal state with borrow, wrap
    add(1, 1, 0, 4'd1, 4'd9, 4'd1, 1);
    add(1, 0, 0, 4'd1, 4'd9, 4'd0, 0);
    add(1, 0, 0, 4'd1, 4'd9, 4'd5, 1);
    add(1, 0, 0, 4'd1, 4'd9, 4'd4, 1);
    add(1, 1, 0, 4'd15, 4'd9, CLAMP ? 4'd5 : 4'd4, 1);
    add(1, 0, 1, 4'd15, 4'd9, CLAMP ? 4'd5 : 4'd4, 1);

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].rst, vecs[k].load, vecs[k].enablen, vecs[k].in, vecs[k].ncs);
      step_check($sformatf("vec%0d", k), vecs[k].exp_count, vecs[k].exp_rco);
    end

    // in=7 load with ncs=9: count 5..1 no borrow, 0 borrows combinationally, then wrap
    @(negedge clk); drive(0, 0, 1, 4'd0, 4'd9);
    step_check("seq26 reset", 4'd0, 1);
    @(negedge clk); drive(1, 1, 0, 4'd7, 4'd9);
    step_check("seq26 load7", CLAMP ? 4'd5 : 4'd0, CLAMP ? 1'b1 : 1'b0);
    if (!CLAMP) begin
      @(negedge clk); drive(1, 1, 0, 4'd5, 4'd9);
      step_check("seq26 load5", 4'd5, 1);
    end
    for (int c = 4; c >= 1; c--) begin
      @(negedge clk); drive(1, 0, 0, 4'd7, 4'd9);
      step_check($sformatf("seq26 dec%0d", c), c[3:0], 1);
    end
    @(negedge clk); drive(1, 0, 0, 4'd7, 4'd9);
    step_check("seq26 dec0", 4'd0, 0);
    @(negedge clk); next_count_state = 4'd8; #1;
    check("seq26 rco ncs8", {3'b0, rco_L}, 4'd1);
    next_count_state = 4'd9; #1;
    check("seq26 rco ncs9", {3'b0, rco_L}, 4'd0);
    step_check("seq26 wrap", 4'd5, 1);

    // in=1 loaded, reach 0 with borrow, then disable at 0: rco_L releases and count holds
    @(negedge clk); drive(1, 1, 0, 4'd1, 4'd9);
    step_check("seq27 load1", 4'd1, 1);
    @(negedge clk); drive(1, 0, 0, 4'd1, 4'd9);
    step_check("seq27 dec0", 4'd0, 0);
    @(negedge clk); enablen = 1'b1; #1;
    check("seq27 rco en1", {3'b0, rco_L}, 4'd1);
    step_check("seq27 hold", 4'd0, 1);
    step_check("seq27 hold2", 4'd0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
